// File: rtl/udp_tx_arb_pkg.sv
// Shared types and widths for the UDP TX arbiter: FSM state encoding,
// the UDPv4 TX bus record and the counter width.
package udp_tx_arb_pkg;

  localparam int MAX_ARB_PORTS = 16;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANTED,
    ARB_ACTIVE,
    ARB_GAP
  } arb_state_t;

  // One beat of the application -> UDP engine transmit interface.
  typedef struct packed {
    logic        start;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] payload_len;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } udpv4_tx_bus_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_select.sv
// Round-robin priority search: first asserted request at or after the
// pointer, wrapping around. Purely combinational.
module rr_priority_select #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] onehot_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    int           cand;
    logic [IDX_W-1:0] cand_idx;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o            = 1'b1;
        onehot_o[cand_idx] = 1'b1;
        idx_o              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UDP TX engine between
// NUM_PORTS applications. The owner's bus is forwarded with one cycle of
// latency; a guard gap after each packet lets the engine drain its FIFO.
// Optional watchdog abort of overlong packets: define UDP_TX_ARB_WATCHDOG_EN.
module udp_tx_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int GRANT_TIMEOUT  = 16,
  parameter int MAX_PKT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  input  udpv4_tx_bus_t        app_tx_bus [NUM_PORTS],
  output udpv4_tx_bus_t        tx_l4_bus,
  output logic                 busy,
  output logic                 wdog_drop
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  udpv4_tx_bus_t          out_q, out_d;
  logic                   wdog_q, wdog_d;

  logic [NUM_PORTS-1:0]   sel_onehot;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valid;
  logic [IDX_W-1:0]       ptr_after_owner;
  logic                   enter_gap;
  udpv4_tx_bus_t          owner_bus;

  rr_priority_select #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_rr_select (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .onehot_o(sel_onehot),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign owner_bus       = app_tx_bus[owner_q];
  assign ptr_after_owner = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

`ifndef UDP_TX_ARB_WATCHDOG_EN
  // Watchdog limit has no consumer in this build.
  logic [CNT_W-1:0] unused_wdog_limit;
  assign unused_wdog_limit = CNT_W'(MAX_PKT_CYCLES);
`endif

  // Next-state, counters and the output beat to register.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    out_d     = '0;
    wdog_d    = 1'b0;
    enter_gap = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          state_d = ARB_GRANTED;
          owner_d = sel_idx;
          grant_d = sel_onehot;
          cnt_d   = '0;
        end
      end

      ARB_GRANTED: begin
        // Header fields track the owner so they are stable after start.
        out_d.dst_ip      = owner_bus.dst_ip;
        out_d.src_port    = owner_bus.src_port;
        out_d.dst_port    = owner_bus.dst_port;
        out_d.payload_len = owner_bus.payload_len;
        if (owner_bus.start) begin
          out_d.start = 1'b1;
          state_d     = ARB_ACTIVE;
          cnt_d       = '0;
        end else if (!req[owner_q] || cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
          enter_gap = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ARB_ACTIVE: begin
        out_d       = owner_bus;
        out_d.start = 1'b0;
        if (!owner_bus.data_valid) begin
          out_d.bytes_valid = '0;
          out_d.data        = '0;
        end
        if (owner_bus.drop) begin
          out_d.commit = 1'b0;
          enter_gap    = 1'b1;
        end else if (owner_bus.commit) begin
          enter_gap = 1'b1;
        end
`ifdef UDP_TX_ARB_WATCHDOG_EN
        else if (cnt_q == CNT_W'(MAX_PKT_CYCLES)) begin
          out_d.drop = 1'b1;
          wdog_d     = 1'b1;
          enter_gap  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ARB_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    if (enter_gap) begin
      state_d = ARB_GAP;
      grant_d = '0;
      ptr_d   = ptr_after_owner;
      cnt_d   = '0;
    end
  end

  // State, ownership and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      wdog_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      wdog_q  <= wdog_d;
    end
  end

  assign grant     = grant_q;
  assign tx_l4_bus = out_q;
  assign busy      = (state_q != ARB_IDLE);
  assign wdog_drop = wdog_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: applications react to grant,
// non-owners inject random noise, expectations come from a packet-level model.
module tb_udp_tx_arbiter;
  import udp_tx_arb_pkg::*;

  localparam int NP   = 4;
  localparam int GAP  = 4;
  localparam int TMO  = 16;
  localparam int MAXP = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] grant;
  udpv4_tx_bus_t app [NP];
  udpv4_tx_bus_t tx;
  logic          busy;
  logic          wdog_drop;

  int checks = 0;
  int failures = 0;
  int rr_ptr = 0;

  always #5 clk = ~clk;

  udp_tx_arbiter #(
    .NUM_PORTS(NP), .GAP_CYCLES(GAP), .GRANT_TIMEOUT(TMO), .MAX_PKT_CYCLES(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .app_tx_bus(app), .tx_l4_bus(tx), .busy(busy), .wdog_drop(wdog_drop)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    logic [NP-1:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  function automatic udpv4_tx_bus_t rand_bus();
    udpv4_tx_bus_t b;
    b.start = 1'($urandom);       b.dst_ip = $urandom;
    b.src_port = 16'($urandom);   b.dst_port = 16'($urandom);
    b.payload_len = 16'($urandom); b.data_valid = 1'($urandom);
    b.bytes_valid = 3'($urandom); b.data = $urandom;
    b.commit = 1'($urandom);      b.drop = 1'($urandom);
    return b;
  endfunction

  function automatic udpv4_tx_bus_t rand_hdr();
    udpv4_tx_bus_t b;
    b = '0;
    b.dst_ip = $urandom;          b.src_port = 16'($urandom);
    b.dst_port = 16'($urandom);   b.payload_len = 16'($urandom);
    return b;
  endfunction

  // Expected forwarded beat for an owner beat in the middle/end of a packet.
  function automatic udpv4_tx_bus_t fwd(input udpv4_tx_bus_t b);
    udpv4_tx_bus_t r;
    r = b;
    r.start = 1'b0;
    if (!r.data_valid) begin
      r.data = '0;
      r.bytes_valid = '0;
    end
    if (r.drop) r.commit = 1'b0;
    return r;
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] r, input int ptr);
    for (int i = 0; i < NP; i++)
      if (r[(ptr + i) % NP]) return (ptr + i) % NP;
    return 0;
  endfunction

  task automatic noise(input int except);
    for (int i = 0; i < NP; i++)
      if (i != except) app[i] = rand_bus();
  endtask

  // Counts grant-low samples from now until a grant appears.
  task automatic wait_grant(input int exp_p, input int exp_low);
    int low = 0;
    int busy_low = 0;
    bit strobe_seen = 0;
    while (grant == '0 && low < 200) begin
      if (tx.start || tx.data_valid || tx.commit || tx.drop) strobe_seen = 1;
      if (!busy) busy_low++;
      low++;
      noise(-1);
      cyc();
    end
    check("grant_owner", 128'(grant), 128'(oh(exp_p)));
    check("gap_strobes_zero", 128'(strobe_seen), 128'(1'b0));
    if (exp_low >= 0) begin
      check("gap_len", 128'(low), 128'(exp_low));
      check("idle_busy_low", 128'(busy_low), 128'(1));
    end
  endtask

  // Owner p (grant visible now) sends a packet; kind 0=commit 1=drop 2=both.
  task automatic send_pkt(input int p, input int nwords, input int kind,
                          input bit extra_start, input logic [NP-1:0] next_req);
    udpv4_tx_bus_t hdr, b;
    int w = 0;
    hdr = rand_hdr();
    noise(p); b = hdr; b.start = 1'b1; app[p] = b; cyc();
    check("start_beat", 128'(tx), 128'(b));
    check("busy_active", 128'(busy), 128'(1'b1));
    while (w < nwords) begin
      noise(p);
      b = hdr;
      b.data = $urandom;
      b.bytes_valid = 3'($urandom);
      b.data_valid = ($urandom_range(0, 3) != 0);
      b.start = extra_start && ($urandom_range(0, 1) == 1);
      if (b.data_valid) w++;
      app[p] = b;
      cyc();
      check("data_beat", 128'(tx), 128'(fwd(b)));
      check("grant_hold", 128'(grant), 128'(oh(p)));
    end
    noise(p); b = hdr;
    b.commit = (kind != 1);
    b.drop = (kind != 0);
    app[p] = b;
    cyc();
    check("end_beat", 128'(tx), 128'(fwd(b)));
    check("end_grant_clear", 128'(grant), 128'(0));
    check("end_no_wdog", 128'(wdog_drop), 128'(1'b0));
    rr_ptr = (p + 1) % NP;
    app[p] = '0;
    noise(p);
    req = next_req;
    cyc();
  endtask

  initial begin
    udpv4_tx_bus_t b;
    int p_cur;
    int cnt;
    bit seen;
    logic [NP-1:0] nr;

    for (int i = 0; i < NP; i++) app[i] = '0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Idle after reset: nothing granted or forwarded even with bus noise.
    for (int k = 0; k < 8; k++) begin
      check("idle_tx_zero", 128'(tx), 128'(0));
      check("idle_grant_zero", 128'(grant), 128'(0));
      check("idle_busy", 128'(busy), 128'(1'b0));
      noise(-1);
      cyc();
    end

    // Pointer 0 with req=0110 selects port 1; then port 2 after the gap.
    req = 4'b0110;
    wait_grant(1, -1);
    send_pkt(1, 2, 0, 0, 4'b0100);
    wait_grant(2, GAP);

    // Port 2 never starts: grant held GRANT_TIMEOUT cycles, nothing forwarded.
    req = 4'b1100;
    cnt = 0;
    seen = 0;
    while (grant == oh(2) && cnt < 40) begin
      if (tx.start || tx.data_valid || tx.commit || tx.drop) seen = 1;
      cnt++;
      noise(2);
      b = rand_bus();
      b.start = 1'b0;
      app[2] = b;
      cyc();
    end
    check("timeout_len", 128'(cnt), 128'(TMO));
    check("timeout_no_traffic", 128'(seen), 128'(1'b0));
    rr_ptr = 3;
    req = 4'b1000;
    wait_grant(3, GAP + 1);

    // Commit+drop together forwards drop only; repeated start is masked.
    send_pkt(3, 3, 2, 1, 4'b1111);

    // All requesting: round-robin order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      p_cur = rr_pick(req, rr_ptr);
      check("rr_order", 128'(p_cur), 128'(k % NP));
      wait_grant(p_cur, GAP);
      send_pkt(p_cur, 1, 0, 0, 4'b1111);
    end

    // Random request patterns, lengths and endings.
    p_cur = rr_pick(req, rr_ptr);
    wait_grant(p_cur, GAP);
    for (int k = 0; k < 16; k++) begin
      nr = 4'($urandom_range(1, 15));
      send_pkt(p_cur, $urandom_range(1, 4), $urandom_range(0, 2), 1'($urandom), nr);
      p_cur = rr_pick(nr, rr_ptr);
      wait_grant(p_cur, GAP);
    end

`ifdef UDP_TX_ARB_WATCHDOG_EN
    // Start then silence: watchdog drop MAX_PKT_CYCLES+1 cycles after start.
    noise(p_cur); b = rand_hdr(); b.start = 1'b1; app[p_cur] = b; cyc();
    check("wd_start", 128'(tx), 128'(b));
    cnt = 0;
    app[p_cur] = '0;
    while (!tx.drop && cnt < 60) begin
      noise(p_cur);
      cyc();
      cnt++;
    end
    check("wd_latency", 128'(cnt), 128'(MAXP + 1));
    check("wd_pulse", 128'(wdog_drop), 128'(1'b1));
    check("wd_commit_zero", 128'(tx.commit), 128'(1'b0));
    rr_ptr = (p_cur + 1) % NP;
    req = 4'b1111;
    cyc();
    check("wd_pulse_one_cycle", 128'(wdog_drop), 128'(1'b0));
    p_cur = rr_pick(req, rr_ptr);
    wait_grant(p_cur, GAP);
`endif

    // Asynchronous reset in the middle of a packet.
    noise(p_cur); b = rand_hdr(); b.start = 1'b1; app[p_cur] = b; cyc();
    b.start = 1'b0; b.data_valid = 1'b1; b.data = 32'hA5A5_0001; app[p_cur] = b; cyc();
    check("pre_reset_dv", 128'(tx.data_valid), 128'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx_zero", 128'(tx), 128'(0));
    check("rst_grant_zero", 128'(grant), 128'(0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_wdog", 128'(wdog_drop), 128'(1'b0));
    repeat (2) cyc();
    check("rst_hold_tx_zero", 128'(tx), 128'(0));
    for (int i = 0; i < NP; i++) app[i] = '0;
    rst_n = 1'b1;
    rr_ptr = 0;
    req = 4'b0110;
    wait_grant(rr_pick(req, rr_ptr), -1);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
